// File: rtl/mon_prod_radix_if.sv
// -----------------------------------------------------------------------------
// mon_prod_radix_if
// Operand-memory bus between the Montgomery product engine and a synchronous
// single-port-style memory with separate read and write ports.
//
//   rd_addr  engine -> mem   read address
//   rd_data  mem -> engine   mem[rd_addr of the previous cycle]
//   wr_addr  engine -> mem   write address
//   wr_data  engine -> mem   write data
//   wr_en    engine -> mem   write strobe
//
// modport master: the engine side.  modport slave: the memory side.
// -----------------------------------------------------------------------------
interface mon_prod_radix_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 64
);
    logic [ABITS-1:0] rd_addr;
    logic [DBITS-1:0] rd_data;
    logic [ABITS-1:0] wr_addr;
    logic [DBITS-1:0] wr_data;
    logic             wr_en;

    modport master (
        output rd_addr,
        output wr_addr,
        output wr_data,
        output wr_en,
        input  rd_data
    );

    modport slave (
        input  rd_addr,
        input  wr_addr,
        input  wr_data,
        input  wr_en,
        output rd_data
    );
endinterface

// File: rtl/mon_prod_radix.sv
// -----------------------------------------------------------------------------
// mon_prod_radix
// Radix-2^K Montgomery product engine: P = X * Y * 2^(-BITLEN) mod n.
// X is read word by word from X_ADDR; Y is X (XX), M_bar read from M_ADDR (XM)
// or the constant 1 (X1). The result is written back at X_ADDR and held on p.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request, sampled in IDLE only
//   op_code      0 = XX, 1 = XM, 2 = X1, 3 = XX
//   n, n_prime   odd modulus and -n^-1 mod 2^K, stable while busy
//   mem          operand memory bus (master side), all outputs registered
//   busy, done   status; done is a one-cycle pulse after the last write
//   p            last result, held until the next FINAL
// -----------------------------------------------------------------------------
module mon_prod_radix #(
    parameter int ABITS  = 8,
    parameter int DBITS  = 64,
    parameter int BITLEN = 256,
    parameter int K      = 2,
    parameter int X_ADDR = 0,
    parameter int M_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op_code,
    input  logic [BITLEN-1:0]   n,
    input  logic [K-1:0]        n_prime,
    mon_prod_radix_if.master    mem,
    output logic                busy,
    output logic                done,
    output logic [BITLEN-1:0]   p
);
    localparam int WORDS = BITLEN / DBITS;
    localparam int ITERS = BITLEN / K;
    // Accumulator stays below 2n, so BITLEN+K+1 bits never overflow; the
    // intermediate sum needs K more bits before the shift.
    localparam int PW    = BITLEN + K + 1;
    localparam int TW    = PW + K;
    localparam int CW    = $clog2(ITERS + WORDS + 1) + 1;

    localparam logic [CW-1:0] LAST_LOAD  = CW'(WORDS);
    localparam logic [CW-1:0] LAST_STORE = CW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_ITER  = CW'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADA, S_LOADB, S_CALC, S_FINAL, S_STORE, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_XX = 2'd0, OP_XM = 2'd1, OP_X1 = 2'd2, OP_XX_ALT = 2'd3
    } op_e;

    state_e             state_q;
    op_e                op_q;
    logic [CW-1:0]      cnt_q;
    logic [BITLEN-1:0]  a_q, b_q, p_q;
    logic [PW-1:0]      pacc_q;
    logic [ABITS-1:0]   rd_addr_q, wr_addr_q;
    logic [DBITS-1:0]   wr_data_q;
    logic               wr_en_q, busy_q, done_q;

    // Next-state values computed combinationally.
    logic [BITLEN-1:0]  a_d, b_d, p_d;
    logic [PW-1:0]      pacc_d;
    logic [TW-1:0]      t_sum, u_sum;
    logic [K-1:0]       b_digit, q_digit;

    // NOTE: every always_comb output is assigned unconditionally first, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        // Words arrive little-endian; shifting each one in from the top leaves
        // word 0 at the bottom once all WORDS have been captured.
        a_d = (BITLEN'(mem.rd_data) << (BITLEN - DBITS)) | (a_q >> DBITS);
        b_d = (BITLEN'(mem.rd_data) << (BITLEN - DBITS)) | (b_q >> DBITS);

        b_digit = b_q[K-1:0];
        t_sum   = TW'(pacc_q) + TW'(b_digit) * TW'(a_q);
        q_digit = t_sum[K-1:0] * n_prime;
        u_sum   = t_sum + TW'(q_digit) * TW'(n);
        pacc_d  = PW'(u_sum >> K);

        p_d = (pacc_q >= PW'(n)) ? BITLEN'(pacc_q - PW'(n)) : pacc_q[BITLEN-1:0];
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_XX;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            pacc_q    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q      <= op_e'(op_code);
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        // First address goes out now so word 0 is back by
                        // the second LOADA cycle.
                        rd_addr_q <= ABITS'(X_ADDR);
                        state_q   <= S_LOADA;
                    end
                end

                S_LOADA: begin
                    if (cnt_q != '0) a_q <= a_d;
                    if (cnt_q == LAST_LOAD) begin
                        cnt_q <= '0;
                        if (op_q == OP_XM) begin
                            rd_addr_q <= ABITS'(M_ADDR);
                            state_q   <= S_LOADB;
                        end else begin
                            b_q     <= (op_q == OP_X1) ? BITLEN'(1) : a_d;
                            pacc_q  <= '0;
                            state_q <= S_CALC;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q < LAST_LOAD - CW'(1)) rd_addr_q <= rd_addr_q + ABITS'(1);
                    end
                end

                S_LOADB: begin
                    if (cnt_q != '0) b_q <= b_d;
                    if (cnt_q == LAST_LOAD) begin
                        cnt_q   <= '0;
                        pacc_q  <= '0;
                        state_q <= S_CALC;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q < LAST_LOAD - CW'(1)) rd_addr_q <= rd_addr_q + ABITS'(1);
                    end
                end

                S_CALC: begin
                    pacc_q <= pacc_d;
                    b_q    <= b_q >> K;
                    if (cnt_q == LAST_ITER) begin
                        cnt_q   <= '0;
                        state_q <= S_FINAL;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_FINAL: begin
                    p_q     <= p_d;
                    state_q <= S_STORE;
                end

                S_STORE: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= ABITS'(X_ADDR) + ABITS'(cnt_q);
                    wr_data_q <= DBITS'(p_q >> (cnt_q * DBITS));
                    if (cnt_q == LAST_STORE) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DONE: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem.rd_addr = rd_addr_q;
    assign mem.wr_addr = wr_addr_q;
    assign mem.wr_data = wr_data_q;
    assign mem.wr_en   = wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign p           = p_q;
endmodule

// File: tb/tb_mon_prod_radix.sv
// -----------------------------------------------------------------------------
// tb_mon_prod_radix
// Directed bench for mon_prod_radix with BITLEN=16, DBITS=8, n=0xFFF1.
// Two engines share clock, reset and modulus: dut_k2 (K=2, n_prime=3) and
// dut_k4 (K=4, n_prime=15). Each has its own synchronous memory model.
// Hand-derived constants: R = 2^16 mod n = 0x000F, R^-1 mod n = 0xEEE1.
//   X1(0x000F) = 0x0001     XX(0x000F) = 0x000F    XM(0x000F,0x1234) = 0x1234
//   X1(0x1234) = 0x5687     XX(0x0002) = 0xBBB1    XX(0xFFF0) = 0xEEE1
// Latency (start edge to done): K=2 15 / XM 18, K=4 11 / XM 14.
// -----------------------------------------------------------------------------
module tb_mon_prod_radix;
    localparam int ABITS  = 8;
    localparam int DBITS  = 8;
    localparam int BITLEN = 16;
    localparam int X_ADDR = 0;
    localparam int M_ADDR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [BITLEN-1:0] n_mod = 16'hFFF1;

    logic [1:0]             start_v = '0;
    logic [1:0][1:0]        op_v    = '0;
    logic [1:0]             busy_v, done_v;
    logic [1:0][BITLEN-1:0] p_v;

    logic [1:0]       tb_we   = '0;
    logic [ABITS-1:0] tb_addr = '0;
    logic [DBITS-1:0] tb_data = '0;
    logic [DBITS-1:0] mem0 [256];
    logic [DBITS-1:0] mem1 [256];

    int done_cnt0 = 0, done_cnt1 = 0, wr_cnt0 = 0, wr_cnt1 = 0;
    int n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    mon_prod_radix_if #(.ABITS(ABITS), .DBITS(DBITS)) mif0 ();
    mon_prod_radix_if #(.ABITS(ABITS), .DBITS(DBITS)) mif1 ();

    mon_prod_radix #(
        .ABITS(ABITS), .DBITS(DBITS), .BITLEN(BITLEN), .K(2),
        .X_ADDR(X_ADDR), .M_ADDR(M_ADDR)
    ) dut_k2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_code(op_v[0]),
        .n(n_mod), .n_prime(2'd3), .mem(mif0),
        .busy(busy_v[0]), .done(done_v[0]), .p(p_v[0])
    );

    mon_prod_radix #(
        .ABITS(ABITS), .DBITS(DBITS), .BITLEN(BITLEN), .K(4),
        .X_ADDR(X_ADDR), .M_ADDR(M_ADDR)
    ) dut_k4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_code(op_v[1]),
        .n(n_mod), .n_prime(4'd15), .mem(mif1),
        .busy(busy_v[1]), .done(done_v[1]), .p(p_v[1])
    );

    // Synchronous memories: registered read, engine write has priority over
    // the bench preload port (the bench only preloads while the engine idles).
    always @(posedge clk) begin
        mif0.rd_data <= mem0[mif0.rd_addr];
        if (mif0.wr_en) mem0[mif0.wr_addr] <= mif0.wr_data;
        else if (tb_we[0]) mem0[tb_addr] <= tb_data;
    end

    always @(posedge clk) begin
        mif1.rd_data <= mem1[mif1.rd_addr];
        if (mif1.wr_en) mem1[mif1.wr_addr] <= mif1.wr_data;
        else if (tb_we[1]) mem1[tb_addr] <= tb_data;
    end

    always @(posedge clk) begin
        if (done_v[0]) done_cnt0 <= done_cnt0 + 1;
        if (done_v[1]) done_cnt1 <= done_cnt1 + 1;
        if (mif0.wr_en) wr_cnt0 <= wr_cnt0 + 1;
        if (mif1.wr_en) wr_cnt1 <= wr_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DBITS-1:0] mem_at(input int sel, input int a);
        return (sel == 0) ? mem0[a] : mem1[a];
    endfunction

    function automatic int dones(input int sel);
        return (sel == 0) ? done_cnt0 : done_cnt1;
    endfunction

    function automatic int writes(input int sel);
        return (sel == 0) ? wr_cnt0 : wr_cnt1;
    endfunction

    task automatic load_word(input int sel, input int a, input logic [DBITS-1:0] d);
        tb_addr      = ABITS'(a);
        tb_data      = d;
        tb_we[sel]   = 1'b1;
        @(posedge clk);
        #1;
        tb_we = '0;
    endtask

    task automatic run_op(input int sel, input logic [1:0] op, input logic [15:0] x,
                          input logic [15:0] m, input logic [15:0] exp_p,
                          input int exp_lat, input bit toggle, input string tag);
        int cyc;
        int d0;
        int w0;
        load_word(sel, X_ADDR,     x[7:0]);
        load_word(sel, X_ADDR + 1, x[15:8]);
        load_word(sel, M_ADDR,     m[7:0]);
        load_word(sel, M_ADDR + 1, m[15:8]);
        d0 = dones(sel);
        w0 = writes(sel);
        op_v[sel]    = op;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        check({tag, " busy_after_start"}, 64'(busy_v[sel]), 64'd1);
        cyc = 0;
        while (done_v[sel] !== 1'b1 && cyc < 400) begin
            if (toggle) start_v[sel] = (cyc >= 3 && cyc <= 8) ? cyc[0] : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start_v[sel] = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " p"}, 64'(p_v[sel]), 64'(exp_p));
        check({tag, " busy_at_done"}, 64'(busy_v[sel]), 64'd0);
        check({tag, " mem_word0"}, 64'(mem_at(sel, X_ADDR)), 64'(exp_p[7:0]));
        check({tag, " mem_word1"}, 64'(mem_at(sel, X_ADDR + 1)), 64'(exp_p[15:8]));
        check({tag, " write_count"}, 64'(writes(sel) - w0), 64'd2);
        @(posedge clk);
        #1;
        check({tag, " done_pulse_low"}, 64'(done_v[sel]), 64'd0);
        check({tag, " done_pulses"}, 64'(dones(sel) - d0), 64'd1);
    endtask

    initial begin
        int cyc;
        #2;
        check("reset busy",    64'(busy_v[0]),    64'd0);
        check("reset done",    64'(done_v[0]),    64'd0);
        check("reset p",       64'(p_v[0]),       64'd0);
        check("reset wr_en",   64'(mif0.wr_en),   64'd0);
        check("reset rd_addr", 64'(mif0.rd_addr), 64'd0);
        check("reset wr_addr", 64'(mif0.wr_addr), 64'd0);
        check("reset wr_data", 64'(mif0.wr_data), 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // K=2 engine, default-style vectors
        run_op(0, 2'd2, 16'h000F, 16'h0000, 16'h0001, 15, 1'b0, "k2 x1_one");
        run_op(0, 2'd0, 16'h000F, 16'h0000, 16'h000F, 15, 1'b0, "k2 xx_one");
        run_op(0, 2'd1, 16'h000F, 16'h1234, 16'h1234, 18, 1'b0, "k2 xm_1234");
        run_op(0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 15, 1'b1, "k2 x1_zero_toggle");
        run_op(0, 2'd2, 16'h1234, 16'h0000, 16'h5687, 15, 1'b0, "k2 x1_1234");
        run_op(0, 2'd0, 16'h0002, 16'h0000, 16'hBBB1, 15, 1'b0, "k2 xx_2");
        run_op(0, 2'd3, 16'hFFF0, 16'h0000, 16'hEEE1, 15, 1'b0, "k2 op3_nm1");

        // Reset in the middle of CALC
        load_word(0, X_ADDR,     8'h0F);
        load_word(0, X_ADDR + 1, 8'h00);
        op_v[0]    = 2'd0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_calc busy",    64'(busy_v[0]),    64'd0);
        check("rst_calc done",    64'(done_v[0]),    64'd0);
        check("rst_calc wr_en",   64'(mif0.wr_en),   64'd0);
        check("rst_calc p",       64'(p_v[0]),       64'd0);
        check("rst_calc rd_addr", 64'(mif0.rd_addr), 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while a result word is being written
        op_v[0]    = 2'd0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        cyc = 0;
        while (mif0.wr_en !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_store reached_store", 64'(mif0.wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_store wr_en",   64'(mif0.wr_en),   64'd0);
        check("rst_store wr_data", 64'(mif0.wr_data), 64'd0);
        check("rst_store busy",    64'(busy_v[0]),    64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(0, 2'd0, 16'h000F, 16'h0000, 16'h000F, 15, 1'b0, "k2 xx_after_reset");

        // K=4 engine: same results, shorter CALC
        run_op(1, 2'd2, 16'h000F, 16'h0000, 16'h0001, 11, 1'b0, "k4 x1_one");
        run_op(1, 2'd0, 16'h0002, 16'h0000, 16'hBBB1, 11, 1'b0, "k4 xx_2");
        run_op(1, 2'd1, 16'h000F, 16'h1234, 16'h1234, 14, 1'b0, "k4 xm_1234");
        run_op(1, 2'd2, 16'h1234, 16'h0000, 16'h5687, 11, 1'b0, "k4 x1_1234");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
